// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and limits for serial_adder
package serial_adder_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ADD  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - request/result bundle between a client and serial_adder
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/adder1.sv
// rtl/adder1.sv - one-bit combinational full adder
module adder1 (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder sequencing adder1 LSB first
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  generate
    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("serial_adder: WIDTH out of range");
    end
  endgenerate

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             bit_sum;
  logic             bit_cout;
  logic             last;
  logic [WIDTH-1:0] res_nx;
  logic             accept;

  assign accept = (state == ST_IDLE) && bus.start;
  assign last   = (cnt == CW'(WIDTH - 1));

  adder1 u_adder1 (
    .a    (sh_a[0]),
    .b    (sh_b[0]),
    .cin  (carry),
    .sum  (bit_sum),
    .cout (bit_cout)
  );

  // The result shifter only needs the upper WIDTH-1 bits; the newest bit comes straight from adder1.
  generate
    if (WIDTH == 1) begin : g_w1
      assign res_nx = bit_sum;
    end else begin : g_wn
      logic [WIDTH-2:0] sh_s;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sh_s <= '0;
        end else if (state == ST_ADD) begin
          sh_s <= res_nx[WIDTH-1:1];
        end
      end

      assign res_nx = {bit_sum, sh_s};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (bus.start) state_nx = ST_ADD;
      ST_ADD:  if (last) state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == ST_ADD);
    bus.done = (state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a     <= '0;
      sh_b     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      bus.sum  <= '0;
      bus.cout <= 1'b0;
    end else if (accept) begin
      sh_a  <= bus.a;
      sh_b  <= bus.b;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (state == ST_ADD) begin
      sh_a  <= sh_a >> 1;
      sh_b  <= sh_b >> 1;
      carry <= bit_cout;
      cnt   <= cnt + CW'(1);
      // Outputs update only on the final bit so no partial sum is ever visible.
      if (last) begin
        bus.sum  <= res_nx;
        bus.cout <= bit_cout;
      end
    end
  end

endmodule
